// File: rtl/arith_unit.sv
// Execute-stage ALU with a single-cycle datapath and an iterative shift-add MUL.
// Ports: CLOCK/RESET, enable_arith + alu_control + aluin1/aluin2 in; aluout, carry, overflow, zero, result_valid, busy out.
module arith_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             enable_arith,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] aluin1,
    input  logic [WIDTH-1:0] aluin2,
    output logic [WIDTH-1:0] aluout,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             result_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;

    // Single-cycle result path
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH-1:0] res_w;
    logic             c_w;
    logic             v_w;
    logic             msb_a, msb_b, msb_r;

    // One shift-add iteration
    logic [WIDTH-1:0] acc_nxt;
    logic             last_iter;

    assign msb_a = aluin1[WIDTH-1];
    assign msb_b = aluin2[WIDTH-1];
    assign msb_r = res_w[WIDTH-1];

    // Extra top bit receives the last bit shifted out; it stays 0 for shamt=0.
    assign shl_w = {1'b0, aluin1} << aluin2[SHAMT_W-1:0];

    always_comb begin
        sum_w = '0;
        res_w = '0;
        c_w   = 1'b0;
        v_w   = 1'b0;
        unique case (alu_control)
            OP_ADD: begin
                sum_w = {1'b0, aluin1} + {1'b0, aluin2};
                res_w = sum_w[WIDTH-1:0];
                c_w   = sum_w[WIDTH];
                v_w   = (msb_a == msb_b) && (msb_r != msb_a);
            end
            OP_SUB: begin
                sum_w = {1'b0, aluin1} + {1'b0, ~aluin2} + (WIDTH+1)'(1);
                res_w = sum_w[WIDTH-1:0];
                c_w   = sum_w[WIDTH];
                v_w   = (msb_a != msb_b) && (msb_r != msb_a);
            end
            OP_AND: res_w = aluin1 & aluin2;
            OP_OR:  res_w = aluin1 | aluin2;
            OP_XOR: res_w = aluin1 ^ aluin2;
            OP_NOT: res_w = ~aluin1;
            OP_SHL: begin
                res_w = shl_w[WIDTH-1:0];
                c_w   = shl_w[WIDTH];
            end
            OP_MUL: begin
                res_w = '0;
            end
            default: begin
                res_w = '0;
            end
        endcase
    end

    assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_iter = (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        aluout_d = aluout_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable_arith) begin
                    if (alu_control == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = aluin1;
                        mplier_d = aluin2;
                        acc_d    = '0;
                        count_d  = '0;
                    end else begin
                        aluout_d = res_w;
                        carry_d  = c_w;
                        ovf_d    = v_w;
                        zero_d   = (res_w == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (last_iter) begin
                    state_d  = S_IDLE;
                    aluout_d = acc_nxt;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = (acc_nxt == '0);
                    valid_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            aluout_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            aluout_q <= aluout_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign aluout       = aluout_q;
    assign carry        = carry_q;
    assign overflow     = ovf_q;
    assign zero         = zero_q;
    assign result_valid = valid_q;
    assign busy         = (state_q == S_MUL);

endmodule

// File: tb/tb_arith_unit.sv
// Testbench for arith_unit: directed steps plus a result scoreboard.
// Expected results come from an independent reference model.
module tb_arith_unit;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        enable_arith;
    logic [2:0]  alu_control;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [31:0] aluout;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        result_valid;
    logic        busy;

    arith_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .enable_arith (enable_arith),
        .alu_control  (alu_control),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .aluout       (aluout),
        .carry        (carry),
        .overflow     (overflow),
        .zero         (zero),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   nb;
    exp_t last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sbv, sr;
        int     sh;
        e  = '0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            3'd0: begin
                e.r = a + b;
                e.c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                sr  = sa + sbv;
                e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                e.r = a - b;
                e.c = (a >= b);
                sr  = sa - sbv;
                e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: e.r = a ^ b;
            3'd5: e.r = ~a;
            3'd6: begin
                sh  = int'(b[4:0]);
                e.r = a << sh;
                e.c = (sh == 0) ? 1'b0 : a[32-sh];
            end
            default: e.r = a * b;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    // Scoreboard: every result pulse must match the oldest pending request.
    always @(negedge CLOCK) begin
        if (RESET === 1'b1 && result_valid === 1'b1) begin
            exp_t e;
            check("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_aluout", 64'(aluout), 64'(e.r));
                check("sb_carry", 64'(carry), 64'(e.c));
                check("sb_overflow", 64'(overflow), 64'(e.v));
                check("sb_zero", 64'(zero), 64'(e.z));
                last = e;
            end
        end
    end

    // Drive one request at a falling edge; returns at the next falling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        enable_arith = 1'b1;
        alu_control  = op;
        aluin1       = a;
        aluin2       = b;
        if (push) sb.push_back(model(op, a, b));
        @(negedge CLOCK);
    endtask

    task automatic idle(input int n);
        enable_arith = 1'b0;
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic wait_mul(output int cnt, input bit inject);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            if (inject && cnt == 5) begin
                enable_arith = 1'b1;
                alu_control  = 3'd0;
                aluin1       = 32'd1;
                aluin2       = 32'd1;
            end else begin
                enable_arith = 1'b0;
            end
            if (cnt == 10) check("mul_hold", 64'(aluout), 64'(last.r));
            @(negedge CLOCK);
            cnt++;
        end
        enable_arith = 1'b0;
    endtask

    initial begin
        last = '0;
        RESET = 1'b0;
        enable_arith = 1'b1;
        alu_control  = 3'($urandom);
        aluin1       = $urandom;
        aluin2       = $urandom;
        repeat (3) begin
            @(negedge CLOCK);
            alu_control = 3'($urandom);
            aluin1      = $urandom;
            aluin2      = $urandom;
        end
        check("rst_aluout", 64'(aluout), 64'd0);
        check("rst_flags", 64'({carry, overflow, zero}), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        enable_arith = 1'b0;
        RESET = 1'b1;
        idle(3);
        check("idle_aluout", 64'(aluout), 64'd0);
        check("idle_valid", 64'(result_valid), 64'd0);

        issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        enable_arith = 1'b0;
        check("add_ovf_valid", 64'(result_valid), 64'd1);
        check("add_ovf_out", 64'({aluout, carry, overflow, zero}), {29'd0, 32'h8000_0000, 3'b010});
        idle(1);
        check("add_pulse_end", 64'(result_valid), 64'd0);
        check("add_hold", 64'(aluout), 64'h8000_0000);

        issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        enable_arith = 1'b0;
        check("add_wrap_out", 64'({aluout, carry, overflow, zero}), {29'd0, 32'h0, 3'b101});
        idle(1);

        issue(3'd1, 32'd5, 32'd5, 1'b1);
        check("sub0_valid", 64'(result_valid), 64'd1);
        check("sub0_out", 64'({aluout, carry, zero}), {30'd0, 32'h0, 2'b11});
        issue(3'd1, 32'd0, 32'd1, 1'b1);
        enable_arith = 1'b0;
        check("sub1_valid", 64'(result_valid), 64'd1);
        check("sub1_out", 64'({aluout, carry, overflow}), {29'd0, 32'hFFFF_FFFF, 2'b00});
        idle(1);
        check("sub_pulse_end", 64'(result_valid), 64'd0);

        issue(3'd6, 32'h8000_0001, 32'h0000_0021, 1'b1);
        enable_arith = 1'b0;
        check("shl_out", 64'({aluout, carry}), {31'd0, 32'h0000_0002, 1'b1});
        issue(3'd6, 32'hA5A5_A5A5, 32'hFFFF_FFE0, 1'b1);
        issue(3'd6, 32'h0000_0001, 32'h0000_001F, 1'b1);
        issue(3'd6, 32'h0000_0003, 32'h0000_001F, 1'b1);

        for (int i = 0; i < 12; i++)
            issue(3'($urandom_range(0, 6)), $urandom, $urandom, 1'b1);
        issue(3'd2, 32'hF0F0_0000, 32'h0F0F_FFFF, 1'b1);
        issue(3'd5, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        idle(2);

        issue(3'd7, 32'h0000_1234, 32'h0000_0100, 1'b1);
        wait_mul(nb, 1'b1);
        check("mul_busy_cycles", 64'(nb), 64'd32);
        check("mul_valid", 64'(result_valid), 64'd1);
        check("mul_out", 64'({aluout, zero}), {31'd0, 32'h0012_3400, 1'b0});
        idle(3);

        issue(3'd7, $urandom, $urandom, 1'b1);
        wait_mul(nb, 1'b0);
        check("mul2_busy_cycles", 64'(nb), 64'd32);
        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_mul(nb, 1'b0);
        issue(3'd0, 32'd10, 32'd20, 1'b1);
        idle(2);

        issue(3'd7, 32'h0000_00FF, 32'h0000_00FF, 1'b0);
        idle(10);
        check("abort_busy_pre", 64'(busy), 64'd1);
        RESET = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_aluout", 64'(aluout), 64'd0);
        check("abort_valid", 64'(result_valid), 64'd0);
        idle(2);
        RESET = 1'b1;
        idle(40);
        check("abort_no_valid", 64'(result_valid), 64'd0);

        issue(3'd0, 32'd2, 32'd3, 1'b1);
        enable_arith = 1'b0;
        check("post_rst_valid", 64'(result_valid), 64'd1);
        check("post_rst_out", 64'(aluout), 64'd5);
        idle(3);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
